// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/almost-full flag generator for the asynchronous FIFO.
// Everything here runs in the write clock domain; wq2_rptr arrives pre-synchronized.
module fifo_wptr_full #(
    parameter int addr_width = 3,
    parameter int af_level   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [addr_width:0]   wq2_rptr,
    output logic                  w_en,
    output logic [addr_width-1:0] waddr,
    output logic [addr_width:0]   wptr,
    output logic                  wfull,
    output logic                  almost_full
);
    localparam int PW = addr_width + 1;
    // Full means the two MSBs differ and the rest match; for addr_width=1 both bits invert.
    localparam logic [addr_width:0] FULL_MASK = PW'(3) << (addr_width - 1);
    localparam logic [addr_width:0] AF_LEVEL  = PW'(af_level);

    logic [addr_width:0] wbin_q, wbin_d;
    logic [addr_width:0] wptr_q, wptr_d;
    logic                wfull_q, wfull_d;
    logic                af_q, af_d;
    logic [addr_width:0] rbin;
    logic [addr_width:0] level;

    assign w_en = winc & ~wfull_q;

    always_comb begin
        rbin = '0;
        rbin[addr_width] = wq2_rptr[addr_width];
        for (int unsigned i = 1; i <= addr_width; i++) begin
            rbin[addr_width - i] = rbin[addr_width - i + 1] ^ wq2_rptr[addr_width - i];
        end
    end

    always_comb begin
        wbin_d  = wbin_q + {{addr_width{1'b0}}, w_en};
        wptr_d  = (wbin_d >> 1) ^ wbin_d;
        level   = wbin_d - rbin;
        wfull_d = (wptr_d == (wq2_rptr ^ FULL_MASK));
        af_d    = (level >= AF_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            wfull_q <= wfull_d;
            af_q    <= af_d;
        end
    end

    assign waddr       = wbin_q[addr_width-1:0];
    assign wptr        = wptr_q;
    assign wfull       = wfull_q;
    assign almost_full = af_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full (addr_width=3, af_level=6): directed vector table,
// hand-written wrap/reset sequences, and random traffic against a count-based model.
module tb_fifo_wptr_full;
    logic       clk;
    logic       rst;
    logic       winc;
    logic [3:0] wq2_rptr;
    logic       w_en;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic       almost_full;

    int total = 0;
    int bad   = 0;
    logic wen_s;

    fifo_wptr_full #(.addr_width(3), .af_level(6)) dut (
        .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr),
        .w_en(w_en), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       winc;
        logic [3:0] rptr;
        logic       exp_wen;
        logic [3:0] exp_wptr;
        logic [2:0] exp_waddr;
        logic       exp_full;
        logic       exp_af;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic w, input logic [3:0] rp,
                                input logic en, input logic [3:0] p, input logic [2:0] a,
                                input logic f, input logic af);
        vec_t v;
        v.rst = r; v.winc = w; v.rptr = rp; v.exp_wen = en;
        v.exp_wptr = p; v.exp_waddr = a; v.exp_full = f; v.exp_af = af;
        tbl.push_back(v);
    endfunction

    function automatic logic [3:0] gray(input int n);
        int m;
        m = n % 16;
        return 4'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; w_en sampled mid-cycle, outputs 1 after the edge.
    task automatic cyc(input logic r, input logic w, input logic [3:0] rp);
        rst = r; winc = w; wq2_rptr = rp;
        #1 wen_s = w_en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wc;
        int rc;
        bit mfull;
        bit maf;
        bit saw_wrap;
        logic [3:0] prev;
        logic r_r;
        logic w_r;

        rst = 1'b1; winc = 1'b0; wq2_rptr = '0; wen_s = 1'b0;
        @(posedge clk);
        #1;

        // Reset with winc high, then fill from empty, write while full, release and refill.
        for (int i = 0; i < 3; i++) add(1, 1, 4'd0, 1, 4'd0, 3'd0, 0, 0);
        add(0, 1, 4'd0, 1, 4'd1,  3'd1, 0, 0);
        add(0, 1, 4'd0, 1, 4'd3,  3'd2, 0, 0);
        add(0, 1, 4'd0, 1, 4'd2,  3'd3, 0, 0);
        add(0, 1, 4'd0, 1, 4'd6,  3'd4, 0, 0);
        add(0, 1, 4'd0, 1, 4'd7,  3'd5, 0, 0);
        add(0, 1, 4'd0, 1, 4'd5,  3'd6, 0, 1);
        add(0, 1, 4'd0, 1, 4'd4,  3'd7, 0, 1);
        add(0, 1, 4'd0, 1, 4'd12, 3'd0, 1, 1);
        for (int i = 0; i < 5; i++) add(0, 1, 4'd0, 0, 4'd12, 3'd0, 1, 1);
        add(0, 0, 4'd1, 0, 4'd12, 3'd0, 0, 1);
        add(0, 1, 4'd1, 1, 4'd13, 3'd1, 1, 1);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].winc, tbl[i].rptr);
            chk($sformatf("vec%0d w_en", i), wen_s, tbl[i].exp_wen);
            chk($sformatf("vec%0d wptr", i), wptr, tbl[i].exp_wptr);
            chk($sformatf("vec%0d waddr", i), waddr, tbl[i].exp_waddr);
            chk($sformatf("vec%0d wfull", i), wfull, tbl[i].exp_full);
            chk($sformatf("vec%0d almost_full", i), almost_full, tbl[i].exp_af);
        end

        // Wrap-around with the read pointer trailing four entries behind.
        cyc(1, 0, 4'd0);
        wc = 0;
        saw_wrap = 0;
        for (int i = 0; i < 20; i++) begin
            prev = wptr;
            cyc(0, 1, gray(wc > 4 ? wc - 4 : 0));
            wc++;
            chk("wrap w_en", wen_s, 1);
            chk("wrap onebit", $countones(prev ^ wptr), 1);
            chk("wrap wptr", wptr, gray(wc));
            chk("wrap wfull", wfull, 0);
            if (prev == 4'd8 && wptr == 4'd0) saw_wrap = 1;
        end
        chk("wrap 8->0 seen", saw_wrap, 1);

        // Reset mid-fill discards the level at once.
        cyc(1, 0, 4'd0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 4'd0);
        cyc(1, 1, 4'd0);
        chk("midrst wptr", wptr, 0);
        chk("midrst waddr", waddr, 0);
        chk("midrst wfull", wfull, 0);
        chk("midrst af", almost_full, 0);
        cyc(0, 1, 4'd0);
        chk("postrst waddr", waddr, 1);
        chk("postrst wptr", wptr, 1);

        // Random traffic: model holds plain write/read counts, fill = wc - rc.
        cyc(1, 0, 4'd0);
        wc = 0; rc = 0; mfull = 0; maf = 0;
        for (int i = 0; i < 600; i++) begin
            r_r = ($urandom_range(59) == 0);
            w_r = ($urandom_range(3) != 0);
            if (r_r) rc = 0;
            else if (rc < wc && $urandom_range(2) == 0) rc++;
            prev = wptr;
            cyc(r_r, w_r, gray(rc));
            chk("rnd w_en", wen_s, w_r & ~mfull);
            if (r_r) begin
                wc = 0; rc = 0;
            end else if (w_r && !mfull) begin
                wc++;
            end
            mfull = ((wc - rc) == 8);
            maf   = ((wc - rc) >= 6);
            chk("rnd wptr", wptr, gray(wc));
            chk("rnd waddr", waddr, wc % 8);
            chk("rnd wfull", wfull, mfull);
            chk("rnd almost_full", almost_full, maf);
            if (!r_r) chk("rnd onebit", $countones(prev ^ wptr), (w_r && wen_s) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side pointer and full-flag generator for the team's asynchronous FIFO. It keeps the binary write counter and drives the RAM write address. It also produces the Gray-coded write pointer that the read domain's double-flop synchronizer samples. Full and almost-full are derived by comparing against the read pointer, which arrives already synchronized into the write clock domain. The block sits entirely in the write clock domain, between the write client, the dual-port RAM and the pointer synchronizers.

## Interface
- addr_width, 3, RAM address width; FIFO depth = 2^addr_width; pointers are addr_width+1 bits.
- af_level, 6, fill level (entries) at or above which almost_full asserts; legal range 1 .. 2^addr_width.

- clk  input  1  write-domain clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high; sampled on rising edge of clk.
- winc  input  1  write request from client.
- wq2_rptr  input  addr_width+1  Gray read pointer, already synchronized into clk domain.
- w_en  output  1  combinational: winc & ~wfull; RAM write enable; the write is accepted this cycle.
- waddr  output  addr_width  registered RAM write address = low addr_width bits of the binary write counter.
- wptr  output  addr_width+1  registered Gray write pointer, to read-domain synchronizer.
- wfull  output  1  registered full flag.
- almost_full  output  1  registered, fill level >= af_level.

## Operation
- State: wbin (addr_width+1 bit binary counter), wptr (Gray), wfull, almost_full.
- wbin_next = wbin + w_en, modulo 2^(addr_width+1); natural wrap, no saturation.
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- On each edge: wbin <= wbin_next; wptr <= wgray_next.
- Full test is evaluated on next values:
  - wfull <= (wgray_next == {~wq2_rptr[addr_width:addr_width-1], wq2_rptr[addr_width-2:0]}).
  - Special case: for addr_width = 1, invert both bits of wq2_rptr.
- Almost-full:
  - rbin = Gray-to-binary of wq2_rptr, computed combinationally as an XOR prefix from the MSB.
  - level = (wbin_next - rbin) mod 2^(addr_width+1).
  - almost_full <= (level >= af_level).
- Writes while wfull=1: w_en=0 and all state holds. Dropped requests are not flagged; the client must gate on wfull.
- wptr changes by exactly one bit per accepted write, including across the 2^(addr_width+1) wrap. No other transitions are permitted.

## Timing
- Reset (rst=1 at edge): wbin=0, waddr=0, wptr=0, wfull=0, almost_full=0. rst overrides winc in the same cycle. Reset mid-operation discards the fill level immediately.
- w_en has zero latency: it is combinational from winc and the current wfull.
- waddr and wptr advance one cycle after an accepted write. The RAM writes data at the pre-edge waddr.
- wfull asserts on the same edge that accepts the write filling the last entry. The next cycle therefore sees w_en=0 with no overrun.
- wfull deasserts one edge after wq2_rptr changes to a non-full value. End-to-end latency from a read is the synchronizer delay plus 1 cycle, which is conservative.
- A simultaneous write and wq2_rptr change at full cannot happen, because w_en=0 while full. At full-1, both updates are folded into the single next-state evaluation.
- almost_full has the same 1-cycle registered timing as wfull.

## Test plan
- Reset: hold rst=1 with winc=1 for 3 cycles -> waddr=0, wptr=0, wfull=0, almost_full=0, and no advance.
- Fill from empty (addr_width=3, wq2_rptr=0), winc=1 for 8 cycles:
  - wptr sequence is 0,1,3,2,6,7,5,4,12.
  - almost_full rises after the 6th write.
  - wfull rises after the 8th write.
  - w_en=0 on the 9th cycle.
- Write while full: winc=1 for 5 more cycles -> wptr stays 12, waddr stays 0, wfull stays 1.
- Release: set wq2_rptr=1 (one read) -> wfull=0 on the next edge. The next write moves wptr to 13 and wfull reasserts.
- Wrap-around: run 16+ accepted writes with wq2_rptr tracking 4 behind -> wptr passes 8 (Gray) to 0. Every transition differs by one bit, and wfull never asserts.
- Reset mid-fill: assert rst after 5 writes -> all outputs return to 0 on that edge. The next write gives waddr=1, wptr=1.
